counter_ctrl: RTL
=================

# counter_ctrl

Front-end controller that drives the up/down loadable counter. It turns raw push-buttons and switches into the counter's control inputs. Each button is synchronised, debounced and edge-detected into a one-cycle event. A small FSM then converts those events into single-cycle `enable`/`carga` pulses, a direction level `decrese`, and registered `data_in`/`limit` buses. It supports manual single-stepping and prescaled free-running count.

## Interface
- `N`, 4: counter width; width of `sw_data`, `sw_limit`, `data_in`, `limit`.
- `TICK_DIV`, 8: clk cycles per auto-step in RUN; legal range ≥ 2.
- `DB_CYCLES`, 4: consecutive stable samples needed to accept a button change; legal range ≥ 1.
- Reset: `rst`, asynchronous, active-high. Clock: `clk`.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  async active-high reset; all state and outputs cleared.
- `btn_up`  in  1  raw button, asynchronous: step up / select up.
- `btn_down`  in  1  raw button, asynchronous: step down / select down.
- `btn_load`  in  1  raw button, asynchronous: load `sw_data` into the counter.
- `btn_run`  in  1  raw button, asynchronous: toggle STOP/RUN.
- `sw_data`  in  N  load value, quasi-static.
- `sw_limit`  in  N  wrap limit, quasi-static.
- `enable`  out  1  one-cycle step pulse to the counter.
- `decrese`  out  1  direction level: 1 = down.
- `carga`  out  1  one-cycle load pulse.
- `data_in`  out  N  load value captured at the load event.
- `limit`  out  N  registered copy of `sw_limit`.
- `running`  out  1  high while in RUN.

## Operation
- Input path, per button: 2-flop synchroniser, then debouncer, then rising-edge detector giving a one-cycle event (`up_ev`, `down_ev`, `load_ev`, `run_ev`).
- Debouncer behaviour:
  - Holds a `stable` bit and a counter.
  - The counter increments each cycle the synchronised input differs from `stable`; it clears whenever they are equal.
  - On the `DB_CYCLES`-th consecutive mismatch, `stable` flips and the counter clears.
- Only press events are used; releases generate nothing.
- FSM states:
  - STOP, the reset state.
  - RUN.
- Event priority when several events fire in the same cycle: load > down > up > run. Only the highest-priority event is acted on; the others are dropped.
- `load_ev`, in either state:
  - `data_in` <= `sw_data`; `carga` = 1 for one cycle.
  - State unchanged; prescaler unchanged.
- STOP:
  - `up_ev` → `dir` <= 0 and `enable` pulses once.
  - `down_ev` → `dir` <= 1 and `enable` pulses once.
  - `run_ev` → RUN, prescaler cleared.
- RUN:
  - `up_ev`/`down_ev` set `dir` only; no extra pulse.
  - Each prescaler tick gives `enable` = 1 for one cycle.
  - `run_ev` → STOP, prescaler cleared.
- Prescaler counts 0..`TICK_DIV`-1 in RUN only. A tick occurs in the cycle the count equals `TICK_DIV`-1, and the count then wraps to 0.
- If a tick coincides with `load_ev`, `carga` wins, the step is dropped, and the prescaler still wraps. `enable` and `carga` are never both 1.
- `decrese` = `dir` at all times.
- `limit` <= `sw_limit` every cycle.
- `running` = (state == RUN).
- Reset values:
  - `enable`, `carga`, `decrese`, `running`: 0.
  - `data_in`: 0.
  - `limit`: all ones.
  - FSM: STOP; `dir`: 0; prescaler: 0.
  - Debouncers: `stable` = 0, counters = 0; synchronisers: 0.
- Reset mid-operation aborts any pending pulse immediately. A button held through reset release produces a fresh press event once it is debounced.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Press latency: a button first sampled high at edge k, and held, gives `enable`/`carga` high for exactly the cycle following edge k+`DB_CYCLES`+2.
- Bounce shorter than `DB_CYCLES` consecutive samples produces no event.
- RUN step spacing: the first `enable` arrives `TICK_DIV` cycles after the edge that entered RUN. Subsequent pulses are exactly `TICK_DIV` cycles apart.
- A `dir` change takes effect on `decrese` in the same registered cycle as the event, so it is valid for the next step.
- `data_in` is updated on the same edge that raises `carga`.

## Configuration
- `COUNTER_CTRL_DEBOUNCE_EN`, when defined: debouncers are present as described.
- When undefined:
  - `stable` = synchroniser output directly and `DB_CYCLES` is ignored.
  - Press latency becomes edge k+2.
  - All other behaviour is identical.

## Test plan
Bench values: `N`=4, `TICK_DIV`=4, `DB_CYCLES`=3, debounce enabled.
- Reset, no buttons → `enable`=`carga`=`decrese`=`running`=0, `data_in`=0, `limit`=4'hF. After one cycle with `sw_limit`=4'h9, `limit`=4'h9.
- `btn_up` high from edge 10 → a single `enable` pulse in the cycle after edge 15 with `decrese`=0. Holding the button 20 cycles gives no further pulse.
- `btn_down` bouncing 1-0-1-0, then steady high → exactly one `enable` with `decrese`=1, occurring 5 edges after the steady high is first sampled.
- `sw_data`=4'hA, press `btn_load` → `carga`=1 for one cycle, `data_in`=4'hA, `enable`=0 that cycle.
- Press `btn_run` → `running`=1 and `enable` pulses every 4 cycles. Press `btn_down` → pulses continue with `decrese`=1 and no extra pulse. Press `btn_run` → `running`=0 and pulses stop.
- In RUN, assert `rst` between ticks → all outputs go to reset values immediately. After release, the block is in STOP with no `enable` until a new press.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_ctrl_if
//
// Bundles the user-facing controls (raw buttons, switches) and the counter
// control outputs of counter_ctrl into one interface.
//
// Parameter:
//   N         counter width; width of sw_data, sw_limit, data_in, limit
//
// Signals:
//   btn_up    raw button: step up / select up
//   btn_down  raw button: step down / select down
//   btn_load  raw button: load sw_data into the counter
//   btn_run   raw button: toggle STOP/RUN
//   sw_data   load value, quasi-static
//   sw_limit  wrap limit, quasi-static
//   enable    one-cycle step pulse to the counter
//   decrese   direction level, 1 = down
//   carga     one-cycle load pulse
//   data_in   load value captured at the load event
//   limit     registered copy of sw_limit
//   running   high while in RUN
//
// Modports:
//   master    the side that drives buttons/switches and observes the controls
//   slave     counter_ctrl itself
// -----------------------------------------------------------------------------
interface counter_ctrl_if #(
  parameter int N = 4
);

  logic         btn_up;
  logic         btn_down;
  logic         btn_load;
  logic         btn_run;
  logic [N-1:0] sw_data;
  logic [N-1:0] sw_limit;

  logic         enable;
  logic         decrese;
  logic         carga;
  logic [N-1:0] data_in;
  logic [N-1:0] limit;
  logic         running;

  modport master (
    output btn_up,
    output btn_down,
    output btn_load,
    output btn_run,
    output sw_data,
    output sw_limit,
    input  enable,
    input  decrese,
    input  carga,
    input  data_in,
    input  limit,
    input  running
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  btn_load,
    input  btn_run,
    input  sw_data,
    input  sw_limit,
    output enable,
    output decrese,
    output carga,
    output data_in,
    output limit,
    output running
  );

endinterface

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Front-end controller for the up/down loadable counter. Each raw button is
// synchronised, optionally debounced and edge-detected into a one-cycle press
// event. A two-state FSM (STOP/RUN) turns those events into single-cycle
// enable/carga pulses, a direction level and registered data/limit buses.
// In STOP every up/down press steps once; in RUN a prescaler steps the
// counter every TICK_DIV cycles and up/down only select the direction.
//
// Parameters:
//   N          counter width (must match the interface N)
//   TICK_DIV   clk cycles per automatic step in RUN, >= 2
//   DB_CYCLES  consecutive stable samples to accept a button change, >= 1
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset, clears all state and outputs
//   bus        counter_ctrl_if.slave: buttons/switches in, counter controls out
//
// Build option:
//   COUNTER_CTRL_DEBOUNCE_EN  when defined, a debouncer sits between each
//                             synchroniser and edge detector; when undefined
//                             the synchroniser output is used directly and
//                             DB_CYCLES has no effect.
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module counter_ctrl #(
  parameter int N         = 4,
  parameter int TICK_DIV  = 8,
  parameter int DB_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  counter_ctrl_if.slave bus
);

  // Button slots inside the 4-bit per-button vectors.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LOAD = 2;
  localparam int BTN_RUN  = 3;

  // FSM encoding.
  localparam logic [0:0] STOP = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Prescaler sizing: counts 0..TICK_DIV-1.
  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  // Reject illegal parameterisations at elaboration.
  if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_bad_param
    $error("counter_ctrl: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] stable_prev;
  logic [3:0] press;

  assign btn_raw = {bus.btn_run, bus.btn_load, bus.btn_down, bus.btn_up};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef COUNTER_CTRL_DEBOUNCE_EN
  // Counter only has to reach DB_CYCLES-1 before the flip.
  localparam int            DW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [DW-1:0] db_cnt [4];

  // Debouncer: stable flips only after DB_CYCLES consecutive mismatching
  // samples; any matching sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= {DW{1'b0}};
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= {DW{1'b0}};
        end
      end
    end
  end
`else
  // Without the debouncer the synchronised level is taken as-is.
  assign stable = sync2;
`endif

  // Previous debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_prev <= 4'b0000;
    end else begin
      stable_prev <= stable;
    end
  end

  // Presses only; releases are ignored.
  assign press = stable & ~stable_prev;

  logic up_ev;
  logic down_ev;
  logic load_ev;
  logic run_ev;

  assign up_ev   = press[BTN_UP];
  assign down_ev = press[BTN_DOWN];
  assign load_ev = press[BTN_LOAD];
  assign run_ev  = press[BTN_RUN];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          dir;
  logic          dir_nxt;
  logic          step;
  logic          step_nxt;
  logic          load;
  logic          load_nxt;
  logic [N-1:0]  data_reg;
  logic [N-1:0]  data_nxt;
  logic [N-1:0]  limit_reg;
  logic          tick;

  // Next-state decode. Events are mutually exclusive by priority
  // load > down > up > run; the RUN tick runs independently of events but is
  // suppressed by a load so enable and carga never coincide.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    load_nxt  = 1'b0;
    data_nxt  = data_reg;
    tick      = 1'b0;

    // Prescaler free-runs in RUN and rests at zero in STOP.
    if (state == RUN) begin
      tick = (presc == TICK_LAST);
      if (tick) begin
        presc_nxt = {PW{1'b0}};
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end else begin
      presc_nxt = {PW{1'b0}};
    end

    // The default step is the prescaler tick; events below may override.
    step_nxt = tick;

    if (load_ev) begin
      load_nxt = 1'b1;
      data_nxt = bus.sw_data;
      step_nxt = 1'b0;
    end else if (down_ev) begin
      dir_nxt = 1'b1;
      if (state == STOP) begin
        step_nxt = 1'b1;
      end else begin
        step_nxt = tick;
      end
    end else if (up_ev) begin
      dir_nxt = 1'b0;
      if (state == STOP) begin
        step_nxt = 1'b1;
      end else begin
        step_nxt = tick;
      end
    end else if (run_ev) begin
      presc_nxt = {PW{1'b0}};
      case (state)
        STOP:    state_nxt = RUN;
        RUN:     state_nxt = STOP;
        default: state_nxt = STOP;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // FSM state, prescaler and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      presc     <= {PW{1'b0}};
      dir       <= 1'b0;
      step      <= 1'b0;
      load      <= 1'b0;
      data_reg  <= {N{1'b0}};
      limit_reg <= {N{1'b1}};
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      dir       <= dir_nxt;
      step      <= step_nxt;
      load      <= load_nxt;
      data_reg  <= data_nxt;
      limit_reg <= bus.sw_limit;
    end
  end

  assign bus.enable  = step;
  assign bus.carga   = load;
  assign bus.decrese = dir;
  assign bus.data_in = data_reg;
  assign bus.limit   = limit_reg;
  assign bus.running = (state == RUN);

endmodule
